clkdiv_sched: RTL and testbench

- Programmable clock-enable scheduler that generates divided-rate timing for downstream logic.
- Produces a one-cycle `tick` pulse every N enabled clocks and a near-50% divided waveform `div_out`.
- Accepts a new divide ratio through a load/ack handshake and applies it only at a period boundary, so no period is ever truncated or stretched.
- Sits between the control logic and any block that needs a slow timing strobe derived from `clk`.

---
 rtl/clkdiv_sched_if.sv | 25 ++
 rtl/clkdiv_sched.sv | 109 ++++++++++
 tb/tb_clkdiv_sched.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/clkdiv_sched_if.sv
// Control/status bundle for the clock-enable scheduler: enable, ratio load
// handshake, and the generated timing outputs.
interface clkdiv_sched_if #(
  parameter int unsigned W = 8
);
  logic         enable;
  logic [W-1:0] div_in;
  logic         div_load;
  logic         div_ack;
  logic         busy;
  logic         err;
  logic         tick;
  logic         div_out;
  logic [W-1:0] count;

  modport master (
    output enable, div_in, div_load,
    input  div_ack, busy, err, tick, div_out, count
  );

  modport slave (
    input  enable, div_in, div_load,
    output div_ack, busy, err, tick, div_out, count
  );
endinterface

// File: rtl/clkdiv_sched.sv
// Programmable clock-enable scheduler: tick every N enabled clocks, ~50% divided
// waveform, and a new ratio that takes effect only at a period boundary.
module clkdiv_sched #(
  parameter int unsigned W       = 8,
  parameter int unsigned DEF_DIV = 3
) (
  input  logic           clk,
  input  logic           rst,
  clkdiv_sched_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] cur_div_q, cur_div_d;
  logic [W-1:0] pend_div_q, pend_div_d;
  logic         tick_q, tick_d;
  logic         div_out_q, div_out_d;
  logic         div_ack_q, div_ack_d;
  logic         busy_q, busy_d;
  logic         err_q, err_d;

  logic         wrap;
  logic [W-1:0] next_count;

  // State register; reset reinstates the default ratio and drops any pending load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      count_q    <= '0;
      cur_div_q  <= W'(DEF_DIV);
      pend_div_q <= '0;
      tick_q     <= 1'b0;
      div_out_q  <= 1'b0;
      div_ack_q  <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      tick_q     <= tick_d;
      div_out_q  <= div_out_d;
      div_ack_q  <= div_ack_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // Phase counter, waveform and ratio-load FSM.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    tick_d     = 1'b0;
    div_out_d  = div_out_q;
    div_ack_d  = 1'b0;
    err_d      = 1'b0;

    wrap       = bus.enable && (count_q == (cur_div_q - W'(1)));
    next_count = wrap ? '0 : (count_q + W'(1));

    if (bus.enable) begin
      count_d   = next_count;
      tick_d    = wrap;
      div_out_d = (next_count < (cur_div_q >> 1));
    end

    case (state_q)
      ST_RUN: begin
        if (bus.div_load) begin
          if (bus.div_in >= W'(2)) begin
            pend_div_d = bus.div_in;
            state_d    = ST_PEND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_PEND: begin
        // The ack wins over a coincident load so err and div_ack stay exclusive.
        if (wrap) begin
          cur_div_d = pend_div_q;
          div_ack_d = 1'b1;
          state_d   = ST_RUN;
        end else if (bus.div_load) begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase

    busy_d = (state_d == ST_PEND);
  end

  assign bus.count   = count_q;
  assign bus.tick    = tick_q;
  assign bus.div_out = div_out_q;
  assign bus.div_ack = div_ack_q;
  assign bus.busy    = busy_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_clkdiv_sched.sv
// Directed bench for clkdiv_sched; expected values are hand-derived per edge.
module tb_clkdiv_sched;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_mis = 0;

  clkdiv_sched_if #(.W(W)) bus ();

  clkdiv_sched #(.W(W), .DEF_DIV(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_o(input string tag, input int cnt, input bit tk, input bit dv,
                          input bit bz, input bit ak, input bit er);
    chk({tag, ".count"},   32'(bus.count),   32'(cnt));
    chk({tag, ".tick"},    32'(bus.tick),    32'(tk));
    chk({tag, ".div_out"}, 32'(bus.div_out), 32'(dv));
    chk({tag, ".busy"},    32'(bus.busy),    32'(bz));
    chk({tag, ".div_ack"}, 32'(bus.div_ack), 32'(ak));
    chk({tag, ".err"},     32'(bus.err),     32'(er));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int v);
    bus.div_in   = W'(v);
    bus.div_load = 1'b1;
  endtask

  task automatic unload();
    bus.div_load = 1'b0;
  endtask

  initial begin
    rst          = 1'b0;
    bus.enable   = 1'b0;
    bus.div_in   = '0;
    bus.div_load = 1'b0;
    step();
    step();
    expect_o("reset", 0, 0, 0, 0, 0, 0);
    rst        = 1'b1;
    bus.enable = 1'b1;

    // Default ratio 3: tick and div_out high on every third edge
    for (int k = 1; k <= 9; k++) begin
      step();
      expect_o($sformatf("t1_e%0d", k), k % 3, (k % 3) == 0, (k % 3) == 0, 0, 0, 0);
    end

    // Load 8 while count=1
    step();                          expect_o("t2_e10", 1, 0, 0, 0, 0, 0);
    load(8);
    step();                          expect_o("t2_e11", 2, 0, 0, 1, 0, 0);
    unload();
    step();                          expect_o("t2_wrap", 0, 1, 1, 0, 1, 0);
    for (int j = 1; j <= 8; j++) begin
      step();
      expect_o($sformatf("t2_p%0d", j), j % 8, j == 8, (j % 8) < 4, 0, 0, 0);
    end

    // Pending load of 4, then enable low for 5 cycles
    load(4);
    step();                          expect_o("t3_e21", 1, 0, 1, 1, 0, 0);
    unload();
    step();                          expect_o("t3_e22", 2, 0, 1, 1, 0, 0);
    bus.enable = 1'b0;
    for (int j = 0; j < 5; j++) begin
      step();
      expect_o($sformatf("t3_hold%0d", j), 2, 0, 1, 1, 0, 0);
    end
    bus.enable = 1'b1;
    step();                          expect_o("t3_e28", 3, 0, 1, 1, 0, 0);
    step();                          expect_o("t3_e29", 4, 0, 0, 1, 0, 0);
    step();                          expect_o("t3_e30", 5, 0, 0, 1, 0, 0);
    step();                          expect_o("t3_e31", 6, 0, 0, 1, 0, 0);
    step();                          expect_o("t3_e32", 7, 0, 0, 1, 0, 0);
    step();                          expect_o("t3_wrap", 0, 1, 1, 0, 1, 0);
    step();                          expect_o("t3_n4a", 1, 0, 1, 0, 0, 0);
    step();                          expect_o("t3_n4b", 2, 0, 0, 0, 0, 0);
    step();                          expect_o("t3_n4c", 3, 0, 0, 0, 0, 0);
    step();                          expect_o("t3_n4d", 0, 1, 1, 0, 0, 0);

    // Reject div_in=1, accept 5, reject 9 while busy
    load(1);
    step();                          expect_o("t4_bad", 1, 0, 1, 0, 0, 1);
    load(5);
    step();                          expect_o("t4_ld5", 2, 0, 0, 1, 0, 0);
    load(9);
    step();                          expect_o("t4_ld9", 3, 0, 0, 1, 0, 1);
    unload();
    step();                          expect_o("t4_wrap", 0, 1, 1, 0, 1, 0);
    step();                          expect_o("t4_n5a", 1, 0, 1, 0, 0, 0);
    step();                          expect_o("t4_n5b", 2, 0, 0, 0, 0, 0);
    step();                          expect_o("t4_n5c", 3, 0, 0, 0, 0, 0);
    step();                          expect_o("t4_n5d", 4, 0, 0, 0, 0, 0);
    step();                          expect_o("t4_n5e", 0, 1, 1, 0, 0, 0);

    // Back to ratio 3
    load(3);
    step();                          expect_o("t5_ld3", 1, 0, 1, 1, 0, 0);
    unload();
    step();                          expect_o("t5_e48", 2, 0, 0, 1, 0, 0);
    step();                          expect_o("t5_e49", 3, 0, 0, 1, 0, 0);
    step();                          expect_o("t5_e50", 4, 0, 0, 1, 0, 0);
    step();                          expect_o("t5_ack3", 0, 1, 1, 0, 1, 0);
    step();                          expect_o("t5_e52", 1, 0, 0, 0, 0, 0);
    step();                          expect_o("t5_e53", 2, 0, 0, 0, 0, 0);
    // Load 4 on the exact wrap cycle: this wrap and the next period stay at 3
    load(4);
    step();                          expect_o("t5_wrapld", 0, 1, 1, 1, 0, 0);
    unload();
    step();                          expect_o("t5_e55", 1, 0, 0, 1, 0, 0);
    step();                          expect_o("t5_e56", 2, 0, 0, 1, 0, 0);
    step();                          expect_o("t5_ack4", 0, 1, 1, 0, 1, 0);
    step();                          expect_o("t5_n4a", 1, 0, 1, 0, 0, 0);
    step();                          expect_o("t5_n4b", 2, 0, 0, 0, 0, 0);
    step();                          expect_o("t5_n4c", 3, 0, 0, 0, 0, 0);
    step();                          expect_o("t5_n4d", 0, 1, 1, 0, 0, 0);

    // Async reset mid-cycle while a load of 6 is pending
    load(6);
    step();                          expect_o("t6_ld6", 1, 0, 1, 1, 0, 0);
    unload();
    step();                          expect_o("t6_e63", 2, 0, 0, 1, 0, 0);
    #3;
    rst = 1'b0;
    #1;
    expect_o("t6_async", 0, 0, 0, 0, 0, 0);
    step();
    step();                          expect_o("t6_held", 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();                          expect_o("t6_r1", 1, 0, 0, 0, 0, 0);
    step();                          expect_o("t6_r2", 2, 0, 0, 0, 0, 0);
    step();                          expect_o("t6_r3", 0, 1, 1, 0, 0, 0);
    step();                          expect_o("t6_r4", 1, 0, 0, 0, 0, 0);
    step();                          expect_o("t6_r5", 2, 0, 0, 0, 0, 0);
    step();                          expect_o("t6_r6", 0, 1, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
